// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: controller states, bus constants, quarter-bit
// encodings and the per-quarter pin drive table. Also used by the
// write-configuration master on the same camera control bus.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START1,
    ST_W_ID,
    ST_W_X1,
    ST_W_ADDR,
    ST_W_X2,
    ST_STOP1,
    ST_GAP,
    ST_START2,
    ST_R_ID,
    ST_R_X3,
    ST_R_DATA,
    ST_R_NA,
    ST_STOP2
  } sccb_state_e;

  localparam logic [7:0] SCCB_WRITE_ID       = 8'h42;
  localparam int         SCCB_BITS_PER_PHASE = 9;   // 8 data bits + don't-care/ACK slot
  localparam int         SCCB_READ_PERIODS   = 41;  // bit periods in one full read

  localparam logic [1:0] Q_0 = 2'd0;
  localparam logic [1:0] Q_1 = 2'd1;
  localparam logic [1:0] Q_2 = 2'd2;
  localparam logic [1:0] Q_3 = 2'd3;

  // Pin levels {sio_c, sio_d_out, sio_d_oe} for a given state and quarter.
  // Released slots keep sio_d_out at 1 so the pad never glitches low when
  // the output enable comes back.
  function automatic logic [2:0] sccb_drive(input sccb_state_e st,
                                            input logic [1:0]  q,
                                            input logic        tx_bit);
    logic       c_hi;
    logic [2:0] pins;
    c_hi = (q == Q_2) || (q == Q_3);
    case (st)
      ST_IDLE, ST_GAP:             pins = 3'b111;
      ST_START1, ST_START2:        pins = {1'b1, (q == Q_0) || (q == Q_1), 1'b1};
      ST_STOP1, ST_STOP2:          pins = {c_hi, q == Q_3, 1'b1};
      ST_W_ID, ST_W_ADDR, ST_R_ID: pins = {c_hi, tx_bit, 1'b1};
      ST_R_NA:                     pins = {c_hi, 1'b1, 1'b1};
      default:                     pins = {c_hi, 1'b1, 1'b0};
    endcase
    return pins;
  endfunction

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-bit timebase: divides clk by CLK_DIV into ticks and counts four
// quarters per SCCB bit. Cleared so a new transaction starts on a clean q0.
module sccb_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int             CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_q;
  logic [1:0]    qtr_q;

  assign tick    = (div_q == TC);
  assign quarter = qtr_q;

  // Divider wraps at CLK_DIV-1; each wrap advances the quarter counter.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div_q <= '0;
      qtr_q <= 2'd0;
    end else if (tick) begin
      div_q <= '0;
      qtr_q <= qtr_q + 2'd1;
    end else begin
      div_q <= div_q + CW'(1);
    end
  end

endmodule

// File: rtl/sccb_read_master.sv
// SCCB read initiator: write phase (ID + sub-address), stop, then read
// phase (read ID + one data byte, NACKed), returning the byte on rd_data.
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | bus idle, SIO_C/SIO_D high, waiting for start
// START1    | start condition before the write phase
// W_ID      | sending write ID, MSB first (8 bits)
// W_X1      | don't-care slot after ID, SIO_D released
// W_ADDR    | sending captured sub-address (8 bits)
// W_X2      | don't-care slot after sub-address, SIO_D released
// STOP1     | stop condition ending the write phase
// GAP       | bus idle for one bit between the phases
// START2    | start condition before the read phase
// R_ID      | sending read ID (8 bits)
// R_X3      | don't-care slot after read ID, SIO_D released
// R_DATA    | SIO_D released, slave data sampled mid SIO_C-high (8 bits)
// R_NA      | master drives 1 (NACK)
// STOP2     | final stop; rd_data/done updated on exit
module sccb_read_master
  import sccb_pkg::*;
#(
  parameter logic [7:0] SLAVE_ID = SCCB_WRITE_ID,
  parameter int         CLK_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] reg_address,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       sio_c,
  output logic       sio_d_out,
  output logic       sio_d_oe,
  input  logic       sio_d_in
);

  localparam logic [7:0] READ_ID  = SLAVE_ID | 8'h01;
  localparam logic [2:0] LAST_BIT = 3'(SCCB_BITS_PER_PHASE - 2);

  sccb_state_e state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  tx_sr_q, tx_sr_d;
  logic [7:0]  rx_sr_q;
  logic [7:0]  addr_q;
  logic [1:0]  quarter, quarter_d;
  logic        tick, bit_end, accept;

  logic        busy_q, done_q, sio_c_q, sio_d_out_q, sio_d_oe_q;
  logic [7:0]  rd_data_q;

  sccb_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .tick    (tick),
    .quarter (quarter)
  );

  assign bit_end = tick && (quarter == Q_3);

  // Next bus position: state, bit index, TX byte and quarter after this clock.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tx_sr_d   = tx_sr_q;
    accept    = 1'b0;
    quarter_d = tick ? quarter + 2'd1 : quarter;
    if (state_q == ST_IDLE) begin
      quarter_d = Q_0;
      if (start) begin
        accept  = 1'b1;
        state_d = ST_START1;
      end
    end else if (bit_end) begin
      case (state_q)
        ST_START1: begin
          state_d   = ST_W_ID;
          bit_cnt_d = 3'd0;
          tx_sr_d   = SLAVE_ID;
        end
        ST_W_ID, ST_W_ADDR, ST_R_ID: begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = (state_q == ST_W_ID)   ? ST_W_X1 :
                      (state_q == ST_W_ADDR) ? ST_W_X2 : ST_R_X3;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_sr_d   = {tx_sr_q[6:0], 1'b0};
          end
        end
        ST_W_X1: begin
          state_d   = ST_W_ADDR;
          bit_cnt_d = 3'd0;
          tx_sr_d   = addr_q;
        end
        ST_W_X2:   state_d = ST_STOP1;
        ST_STOP1:  state_d = ST_GAP;
        ST_GAP:    state_d = ST_START2;
        ST_START2: begin
          state_d   = ST_R_ID;
          bit_cnt_d = 3'd0;
          tx_sr_d   = READ_ID;
        end
        ST_R_X3: begin
          state_d   = ST_R_DATA;
          bit_cnt_d = 3'd0;
        end
        ST_R_DATA: begin
          if (bit_cnt_q == LAST_BIT) state_d = ST_R_NA;
          else                       bit_cnt_d = bit_cnt_q + 3'd1;
        end
        ST_R_NA:   state_d = ST_STOP2;
        ST_STOP2:  state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Controller registers; pins are registered from the next position so they
  // change exactly at quarter entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      tx_sr_q     <= 8'h00;
      rx_sr_q     <= 8'h00;
      addr_q      <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_data_q   <= 8'h00;
      sio_c_q     <= 1'b1;
      sio_d_out_q <= 1'b1;
      sio_d_oe_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sr_q   <= tx_sr_d;
      if (accept) addr_q <= reg_address;
      if ((state_q == ST_R_DATA) && tick && (quarter == Q_2))
        rx_sr_q <= {rx_sr_q[6:0], sio_d_in};
      {sio_c_q, sio_d_out_q, sio_d_oe_q} <= sccb_drive(state_d, quarter_d, tx_sr_d[7]);
      busy_q <= (state_d != ST_IDLE);
      done_q <= (state_q == ST_STOP2) && bit_end;
      if ((state_q == ST_STOP2) && bit_end) rd_data_q <= rx_sr_q;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_data   = rd_data_q;
  assign sio_c     = sio_c_q;
  assign sio_d_out = sio_d_out_q;
  assign sio_d_oe  = sio_d_oe_q;

endmodule

// File: tb/tb_sccb_read_master.sv
// Bench for sccb_read_master: two instances (CLK_DIV 1 and 4), each with a
// bus-decoding slave holding a register map; expected read data and timing
// are queued at issue time and checked by a monitor on every done pulse.
module tb_sccb_read_master;
  import sccb_pkg::*;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    int         n;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [1:0] rst_w, start_w, busy_w, done_w, sio_c_w, sio_d_out_w, sio_d_oe_w, sda_w;
  logic [7:0] addr_w [2];
  logic [7:0] rd_data_w [2];

  logic [1:0] s_in, s_oe, s_bit, s_read, s_exp_rd, p_c, p_d;
  logic [7:0] s_sh [2];
  logic [7:0] s_data [2];
  int         sb [2];
  int         busy_n [2];
  int         rel_n [2];
  int         low_n [2];

  logic [7:0] mem [256];
  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_err = 0;

  // Open-drain style bus with pull-up: master, else slave, else 1.
  assign sda_w = (sio_d_oe_w & sio_d_out_w) | (~sio_d_oe_w & s_oe & s_bit) | (~sio_d_oe_w & ~s_oe);

  sccb_read_master #(.SLAVE_ID(8'h42), .CLK_DIV(1)) u_dut0 (
    .clk(clk), .rst(rst_w[0]), .start(start_w[0]), .reg_address(addr_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .rd_data(rd_data_w[0]), .sio_c(sio_c_w[0]),
    .sio_d_out(sio_d_out_w[0]), .sio_d_oe(sio_d_oe_w[0]), .sio_d_in(sda_w[0]));

  sccb_read_master #(.SLAVE_ID(8'h42), .CLK_DIV(4)) u_dut1 (
    .clk(clk), .rst(rst_w[1]), .start(start_w[1]), .reg_address(addr_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .rd_data(rd_data_w[1]), .sio_c(sio_c_w[1]),
    .sio_d_out(sio_d_out_w[1]), .sio_d_oe(sio_d_oe_w[1]), .sio_d_in(sda_w[1]));

  function automatic int cd(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qhead(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic exp_t qpop(input int i);
    return (i == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string what);
    n_cmp++;
    n_err++;
    $display("FAIL %s (cycle %0d)", what, cyc);
  endtask

  // Slave: decodes start/stop and bits from the pins, ACKs, returns mem[addr].
  task automatic slave_step(input int i);
    logic c, d;
    exp_t e;
    c = sio_c_w[i];
    d = sio_d_oe_w[i] ? sio_d_out_w[i] : (s_oe[i] ? s_bit[i] : 1'b1);
    if (rst_w[i]) begin
      s_in[i] = 1'b0; s_oe[i] = 1'b0; s_exp_rd[i] = 1'b0; sb[i] = -1;
      p_c[i] = 1'b1;  p_d[i] = 1'b1;
      return;
    end
    if (p_c[i] && c && p_d[i] && !d) begin
      s_in[i] = 1'b1; s_oe[i] = 1'b0; s_read[i] = 1'b0; sb[i] = -1;
    end else if (p_c[i] && c && !p_d[i] && d) begin
      s_in[i] = 1'b0; s_oe[i] = 1'b0; s_exp_rd[i] = ~s_read[i];
    end else if (s_in[i] && p_c[i] && !c) begin
      sb[i]++;
      s_oe[i] = 1'b0;
      if (sb[i] == 8 || (!s_read[i] && sb[i] == 17)) begin
        s_oe[i] = 1'b1; s_bit[i] = 1'b0;
      end
      if (s_read[i] && sb[i] >= 9 && sb[i] <= 16) begin
        s_oe[i] = 1'b1; s_bit[i] = s_data[i][16 - sb[i]];
      end
    end else if (s_in[i] && !p_c[i] && c) begin
      if (sb[i] >= 0 && sb[i] <= 7) begin
        s_sh[i] = {s_sh[i][6:0], d};
        if (sb[i] == 7) begin
          s_read[i] = d;
          chk($sformatf("dut%0d bus slave id", i), 32'(s_sh[i]), s_exp_rd[i] ? 32'h43 : 32'h42);
        end
      end else if (!s_read[i] && sb[i] >= 9 && sb[i] <= 16) begin
        s_sh[i] = {s_sh[i][6:0], d};
        if (sb[i] == 16) begin
          s_data[i] = mem[s_sh[i]];
          if (qsize(i) > 0) begin
            e = qhead(i);
            chk($sformatf("dut%0d bus sub-address", i), 32'(s_sh[i]), 32'(e.addr));
          end else begin
            flag($sformatf("dut%0d unexpected bus transaction", i));
          end
        end
      end else if (s_read[i] && sb[i] == 17) begin
        chk($sformatf("dut%0d master NA bit", i), 32'(d), 32'h1);
      end
    end
    p_c[i] = c;
    p_d[i] = d;
  endtask

  // Monitor: contention, SIO_C low width, and scoreboard check on done.
  task automatic mon_step(input int i);
    exp_t e;
    if (rst_w[i]) begin
      busy_n[i] = 0; rel_n[i] = 0; low_n[i] = 0;
      return;
    end
    if (busy_w[i]) begin
      busy_n[i]++;
      if (!sio_d_oe_w[i]) rel_n[i]++;
    end
    if (s_oe[i] && sio_d_oe_w[i]) flag($sformatf("dut%0d bus contention", i));
    if (!sio_c_w[i]) low_n[i]++;
    else if (low_n[i] > 0) begin
      chk($sformatf("dut%0d sio_c low width", i), 32'(low_n[i]), 32'(2 * cd(i)));
      low_n[i] = 0;
    end
    if (done_w[i]) begin
      if (qsize(i) == 0) begin
        flag($sformatf("dut%0d done with no read outstanding", i));
      end else begin
        e = qpop(i);
        chk($sformatf("dut%0d rd_data", i), 32'(rd_data_w[i]), 32'(e.data));
        chk($sformatf("dut%0d done cycle", i), 32'(cyc), 32'(e.n + 1 + SCCB_READ_PERIODS * 4 * cd(i)));
        chk($sformatf("dut%0d busy length", i), 32'(busy_n[i]), 32'(SCCB_READ_PERIODS * 4 * cd(i)));
        chk($sformatf("dut%0d released clocks", i), 32'(rel_n[i]), 32'(11 * 4 * cd(i)));
        chk($sformatf("dut%0d busy at done", i), 32'(busy_w[i]), 32'h0);
      end
      busy_n[i] = 0;
      rel_n[i]  = 0;
    end
  endtask

  always @(negedge clk) begin
    slave_step(0);
    slave_step(1);
    mon_step(0);
    mon_step(1);
  end

  task automatic issue(input int i, input logic [7:0] a);
    exp_t e;
    e.addr = a;
    e.data = mem[a];
    e.n    = cyc;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
    start_w[i] = 1'b1;
    addr_w[i]  = a;
    @(posedge clk); #1;
    start_w[i] = 1'b0;
    addr_w[i]  = 8'($urandom);
  endtask

  task automatic wait_done(input int i);
    for (int k = 0; k < 200 * 4 * cd(i); k++) begin
      if (done_w[i]) break;
      @(posedge clk); #1;
    end
    if (!done_w[i]) flag($sformatf("dut%0d timeout waiting for done", i));
  endtask

  task automatic check_reset_pins(input int i, input string tag);
    chk($sformatf("dut%0d %s busy", i, tag), 32'(busy_w[i]), 32'h0);
    chk($sformatf("dut%0d %s done", i, tag), 32'(done_w[i]), 32'h0);
    chk($sformatf("dut%0d %s sio_c", i, tag), 32'(sio_c_w[i]), 32'h1);
    chk($sformatf("dut%0d %s sio_d_out", i, tag), 32'(sio_d_out_w[i]), 32'h1);
    chk($sformatf("dut%0d %s sio_d_oe", i, tag), 32'(sio_d_oe_w[i]), 32'h1);
    chk($sformatf("dut%0d %s rd_data", i, tag), 32'(rd_data_w[i]), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    mem[8'h0A] = 8'h76;
    mem[8'h1C] = 8'h7F;
    mem[8'h0B] = 8'h73;
    for (int i = 0; i < 2; i++) begin
      addr_w[i] = 8'h00; sb[i] = -1; busy_n[i] = 0; rel_n[i] = 0; low_n[i] = 0;
      s_sh[i] = 8'h00; s_data[i] = 8'h00;
    end
    s_in = '0; s_oe = '0; s_bit = '1; s_read = '0; s_exp_rd = '0; p_c = '1; p_d = '1;
    rst_w   = 2'b11;
    start_w = 2'b00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_pins(0, "reset");
    check_reset_pins(1, "reset");
    @(posedge clk); #1;
    rst_w = 2'b00;
    repeat (3) begin @(posedge clk); #1; end

    // Basic read, then the divided-clock instance.
    issue(0, 8'h0A);
    wait_done(0);
    repeat (4) begin @(posedge clk); #1; end
    issue(1, 8'h1C);
    wait_done(1);
    repeat (4) begin @(posedge clk); #1; end

    // Start while busy is ignored; start in the done cycle is accepted.
    issue(0, 8'($urandom));
    repeat (18) begin @(posedge clk); #1; end
    start_w[0] = 1'b1;
    addr_w[0]  = 8'h55;
    @(posedge clk); #1;
    start_w[0] = 1'b0;
    wait_done(0);
    issue(0, 8'h0B);
    wait_done(0);
    repeat (4) begin @(posedge clk); #1; end

    // Reset during R_DATA bit 3, then a fresh read.
    issue(0, 8'h1C);
    repeat (136) begin @(posedge clk); #1; end
    chk("dut0 released before reset", 32'(sio_d_oe_w[0]), 32'h0);
    rst_w[0] = 1'b1;
    void'(q0.pop_back());
    @(posedge clk);
    @(negedge clk);
    check_reset_pins(0, "mid-read reset");
    @(posedge clk); #1;
    rst_w[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    issue(0, 8'h0A);
    wait_done(0);

    // Random reads on both instances in parallel, with random gaps.
    fork
      begin
        for (int k = 0; k < 16; k++) begin
          if ($urandom_range(0, 2) != 0)
            repeat ($urandom_range(1, 6)) begin @(posedge clk); #1; end
          issue(0, 8'($urandom));
          wait_done(0);
        end
      end
      begin
        for (int k = 0; k < 3; k++) begin
          repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
          issue(1, 8'($urandom));
          wait_done(1);
        end
      end
    join

    repeat (40) begin @(posedge clk); #1; end
    chk("dut0 reads left outstanding", 32'(q0.size()), 32'h0);
    chk("dut1 reads left outstanding", 32'(q1.size()), 32'h0);
    chk("dut0 busy at end", 32'(busy_w[0]), 32'h0);
    chk("dut1 busy at end", 32'(busy_w[1]), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sccb_read_master.md
# sccb_read_master

SCCB (OV7670-style) read initiator: on `start` it performs a 2-phase write transaction (slave ID + register sub-address), a stop, then a 2-phase read transaction (slave read ID + one data byte), and returns the byte on `rd_data`. It sits beside the existing SCCB write-configuration block on the camera control bus and is used for ID checks and register read-back. The block owns SIO_C and drives SIO_D through an external tristate.

## Interface
- `SLAVE_ID`, 8'h42: write ID. The read ID is `SLAVE_ID | 8'h01`.
- `CLK_DIV`, 4: system clocks per quarter-bit tick, ≥1. One SCCB bit period is 4 ticks.
- `clk` in 1: single system clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a read; sampled only in IDLE.
- `reg_address` in 8: sub-address; captured on the accepted `start`.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle pulse, `rd_data` valid.
- `rd_data` out 8: byte read; held until the next `done`.
- `sio_c` out 1: SCCB clock.
- `sio_d_out` out 1: SIO_D drive value.
- `sio_d_oe` out 1: 1 = master drives SIO_D.
- `sio_d_in` in 1: SIO_D pad input.

## Operation
- Reset values: `sio_c`=1, `sio_d_out`=1, `sio_d_oe`=1, `busy`=0, `done`=0, `rd_data`=8'h00. Tick counter = 0, state = IDLE.
- States, in order: IDLE → START1 → W_ID(8) → W_X1(1) → W_ADDR(8) → W_X2(1) → STOP1 → GAP → START2 → R_ID(8) → R_X3(1) → R_DATA(8) → R_NA(1) → STOP2 → IDLE. Counts in parentheses are bits; every other state lasts 1 bit period.
- Each bit period has quarters q0–q3.
  - `sio_c` is 0 in q0–q1 and 1 in q2–q3.
  - The master updates `sio_d_out` and `sio_d_oe` at entry to q0.
- START (both START1 and START2): `sio_c`=1 throughout.
  - `sio_d`=1 in q0–q1, then 0 in q2–q3.
- STOP: `sio_d`=0 in q0–q2.
  - `sio_c`=0 in q0–q1, 1 in q2–q3.
  - `sio_d` rises at q3.
- GAP: `sio_c`=1, `sio_d`=1.
- Data bits are sent MSB first.
  - W_ID sends `SLAVE_ID`.
  - W_ADDR sends the captured address.
  - R_ID sends the read ID.
- Don't-care bits (X1, X2, X3): `sio_d_oe`=0. The input is ignored; no ACK checking.
- R_DATA: `sio_d_oe`=0.
  - `sio_d_in` is sampled on the clock where q2 ends (mid SIO_C-high).
  - Samples shift into a shift register, MSB first.
- R_NA: master drives 1 (NACK).
- Exit of STOP2, same clock:
  - copy the shift register to `rd_data`;
  - pulse `done`;
  - clear `busy`;
  - return to IDLE.
- Tristate safety: `sio_d_oe` returns to 1 at q0 of the bit after each released bit.
- `start` while busy: ignored; no queuing.
- `start` in the `done` cycle: accepted (FSM is already IDLE), enabling back-to-back reads.
- `rst` mid-transaction:
  - next clock forces all reset values, including `sio_c`=1 and `sio_d`=1;
  - `rd_data` cleared;
  - no stop condition is generated.
- `reg_address` changes after acceptance have no effect.

## Timing
- `start` sampled high at edge N (IDLE): `busy`=1 from edge N+1. START1 q0 begins at N+1.
- Transaction length is 41 bit periods = 164·CLK_DIV clocks. `done`=1 and `busy`=0 at edge N+1+164·CLK_DIV.
- Tick counter wraps at CLK_DIV-1. The quarter counter wraps at 3 and advances the bit/state counters.
- `busy` is high for exactly 164·CLK_DIV clocks. `done` is high for exactly 1 clock.
- Minimum `start`-to-`start` interval: 164·CLK_DIV+1 clocks.

## Structure
- `sccb_pkg`:
  - state enum;
  - `SCCB_WRITE_ID` (8'h42);
  - `SCCB_BITS_PER_PHASE` (9);
  - `SCCB_READ_PERIODS` (41);
  - quarter encodings.
  
  The write-configuration block also imports this package.
- Sub-module `sccb_tick_gen`: CLK_DIV divider plus 2-bit quarter counter. It has a synchronous clear on `rst` or on `start` acceptance, and outputs `tick` and `quarter`.
- Top level: FSM, bit counter (0–7), TX shift register, RX shift register.

## Test plan
- Reset values: assert `rst` for 3 clocks → all outputs at reset values, `sio_c`=1, `sio_d_out`=1, `sio_d_oe`=1.
- Basic read: CLK_DIV=1, `reg_address`=8'h0A, slave model returns 8'h76. Required response:
  - bus shows 8'h42, X, 8'h0A, X, stop, start, 8'h43, X;
  - master samples 8'h76, then drives NA=1;
  - `done` at N+165 with `rd_data`=8'h76;
  - `busy` high for exactly 164 clocks.
- Divider: CLK_DIV=4, `reg_address`=8'h1C, slave returns 8'h7F → each `sio_c` level lasts 8 clocks; `done` at N+657 with `rd_data`=8'h7F.
- Busy/back-to-back: pulse `start` at busy cycle 20 → ignored; assert `start` in the `done` cycle with address 8'h0B and slave data 8'h73 → second read begins at once, `rd_data`=8'h73 after 165 more clocks.
- Reset mid-read: `rst` during R_DATA bit 3 → next clock `busy`=0, `sio_c`=1, `sio_d_out`=1, `sio_d_oe`=1, `rd_data`=8'h00; a fresh read then returns correct data.
- Tristate check: `sio_d_oe`=0 exactly during X1, X2, X3 and the 8 R_DATA bits (11 bit periods); the bench flags any other cycle where the slave and master drive together.
